// File: rtl/booth_mac_pkg.sv
// Shared definitions for the Booth multiply-accumulate sequencer: FSM encoding and default sizes.
package booth_mac_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StAccum,
        StDone
    } state_e;

    localparam int unsigned DefOpW      = 8;
    localparam int unsigned DefProdW    = 2 * DefOpW;
    localparam int unsigned DefAccW     = 20;
    localparam int unsigned DefVecLen   = 4;
    localparam int unsigned DefMulCycles = 9;

endpackage

// File: rtl/mac_sat_add.sv
// Signed ACC_W-bit adder with overflow flag; defining SATURATE_EN clamps the sum on overflow,
// otherwise the sum wraps modulo 2^ACC_W.
module mac_sat_add
    import booth_mac_pkg::*;
#(
    parameter int unsigned ACC_W = DefAccW
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] full;

    always_comb begin
        full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // Overflow when the extra sign bit disagrees with the ACC_W-bit sign.
        ovf  = full[ACC_W] ^ full[ACC_W-1];
`ifdef SATURATE_EN
        if (ovf) begin
            sum = full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = full[ACC_W-1:0];
        end
`else
        sum = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/booth_mac_sequencer.sv
// Feeds operand pairs to an external fixed-latency multiplier and accumulates VEC_LEN products
// into a dot-product result. Saturation is selected with the SATURATE_EN macro (see mac_sat_add).
module booth_mac_sequencer
    import booth_mac_pkg::*;
#(
    parameter int unsigned OP_W       = DefOpW,
    parameter int unsigned PROD_W     = DefProdW,
    parameter int unsigned ACC_W      = DefAccW,
    parameter int unsigned VEC_LEN    = DefVecLen,
    parameter int unsigned MUL_CYCLES = DefMulCycles
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              mul_load,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              ovf
);

    localparam int unsigned CntW  = $clog2(VEC_LEN + 1);
    localparam int unsigned WaitW = $clog2(MUL_CYCLES + 1);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    mul_a_q, mul_a_d;
    logic [OP_W-1:0]    mul_b_q, mul_b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CntW-1:0]    elem_q, elem_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;

    assign prod_ext = ACC_W'(signed'(mul_product));

    mac_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        acc_d   = acc_q;
        elem_d  = elem_q;
        wait_d  = wait_q;
        ovf_d   = ovf_q;

        // Abort wins over everything, including a pending result; operands stay as they were.
        if (clr) begin
            state_d = StIdle;
            acc_d   = '0;
            elem_d  = '0;
            wait_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mul_a_d = in_a;
                        mul_b_d = in_b;
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    wait_d  = WaitW'(MUL_CYCLES - 1);
                    state_d = StWait;
                end
                StWait: begin
                    if (wait_q == '0) begin
                        state_d = StAccum;
                    end else begin
                        wait_d = wait_q - WaitW'(1);
                    end
                end
                StAccum: begin
                    acc_d   = add_sum;
                    ovf_d   = ovf_q | add_ovf;
                    elem_d  = elem_q + CntW'(1);
                    state_d = (elem_q == CntW'(VEC_LEN - 1)) ? StDone : StIdle;
                end
                StDone: begin
                    if (out_ready) begin
                        acc_d   = '0;
                        elem_d  = '0;
                        ovf_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
            elem_q  <= '0;
            wait_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            acc_q   <= acc_d;
            elem_q  <= elem_d;
            wait_q  <= wait_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign mul_load  = (state_q == StLoad);
    assign out_valid = (state_q == StDone);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_acc   = acc_q;
    assign ovf       = ovf_q;

endmodule
